// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared pipeline types, FSM encodings and default timeout.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  typedef logic [0:0] state_t;

  localparam state_t C_ST_RUN      = 1'b0;
  localparam state_t C_ST_MEM_WAIT = 1'b1;

  localparam logic [7:0] C_MEM_TIMEOUT_DEFAULT = 8'd255;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard-controller bus; master is the pipeline, slave the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_is_load;
  logic [4:0]  ex_wb_addr;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_wb_addr,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_wb_addr,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           mem_timeout, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Flags an ID instruction reading the destination of a load in EX.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_wb_addr_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = id_uses_rs_i & (id_rs_i == ex_wb_addr_i);
  assign w_rt_hit = id_uses_rt_i & (id_rt_i == ex_wb_addr_i);

  // $zero is never a real dependency
  assign load_use_o = ex_is_load_i & (ex_wb_addr_i != 5'd0) & (w_rs_hit | w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline stall/flush controller with memory-wait FSM and counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = C_MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    bus
);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  ctrl_t       w_ctrl;
  logic        w_load_use;
  logic        w_mem_stall;
  logic        w_timeout;

  load_use_detect u_load_use_detect (
    .ex_is_load_i (bus.ex_is_load),
    .ex_wb_addr_i (bus.ex_wb_addr),
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_uses_rs_i (bus.id_uses_rs),
    .id_uses_rt_i (bus.id_uses_rt),
    .load_use_o   (w_load_use)
  );

  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
  assign w_timeout   = (wait_q == MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= C_ST_RUN;
      wait_q        <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      C_ST_RUN: begin
        if (w_mem_stall) begin
          state_d = C_ST_MEM_WAIT;
          wait_d  = 8'd0;
        end
      end
      C_ST_MEM_WAIT: begin
        wait_d = wait_q + 8'd1;
        // a completing access wins over a coincident timeout
        if (bus.mem_ready) begin
          state_d = C_ST_RUN;
        end else if (w_timeout) begin
          state_d       = C_ST_RUN;
          mem_timeout_d = 1'b1;
        end
      end
      default: state_d = C_ST_RUN;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    if (reset) begin
      w_ctrl.ifid_flush = 1'b1;
      w_ctrl.idex_flush = 1'b1;
    end else begin
      case (state_q)
        C_ST_RUN: begin
          if (w_mem_stall) begin
            w_ctrl = '0;
          end else if (bus.ex_branch_taken) begin
            w_ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
          end else if (w_load_use) begin
            // freeze PC and IF/ID, push a bubble into ID/EX
            w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
          end else begin
            w_ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
          end
        end
        C_ST_MEM_WAIT: begin
          if (bus.mem_ready | w_timeout) begin
            w_ctrl = '{1'b1, 1'b1, 1'b1, 1'b1,
                       bus.ex_branch_taken, bus.ex_branch_taken};
          end
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, ~w_ctrl.pc_en};
      flush_cnt_q <= flush_cnt_q + {31'd0, w_ctrl.ifid_flush};
    end
  end

  assign bus.pc_en       = w_ctrl.pc_en;
  assign bus.ifid_en     = w_ctrl.ifid_en;
  assign bus.idex_en     = w_ctrl.idex_en;
  assign bus.exmem_en    = w_ctrl.exmem_en;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.idex_flush  = w_ctrl.idex_flush;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  // control vector order: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
  localparam logic [5:0] C_RUN   = 6'b111100;
  localparam logic [5:0] C_STALL = 6'b000000;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_LU    = 6'b001101;
  localparam logic [5:0] C_RST   = 6'b000011;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic        clk;
  logic        reset;
  int          errors;
  int          checks;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;
  exp_t        sb_q[$];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (8'd4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rst,
                      input logic ld, input logic [4:0] wb,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic br, input logic req, input logic rdy,
                      input logic [5:0] ectl, input logic eto);
    exp_t       e;
    exp_t       got;
    logic [5:0] obs;
    @(negedge clk);
    reset               = rst;
    bus.ex_is_load      = ld;
    bus.ex_wb_addr      = wb;
    bus.id_rs           = rs;
    bus.id_uses_rs      = urs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = urt;
    bus.ex_branch_taken = br;
    bus.mem_req         = req;
    bus.mem_ready       = rdy;
    e.tag = tag;
    e.ctl = ectl;
    e.to  = eto;
    e.sc  = exp_stall;
    e.fc  = exp_flush;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
           bus.ifid_flush, bus.idex_flush};
    checks++;
    assert (obs === got.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs, got.ctl);
    end
    checks++;
    assert (bus.mem_timeout === got.to) else begin
      errors++;
      $error("FAIL %s mem_timeout observed=%b expected=%b", got.tag, bus.mem_timeout, got.to);
    end
    checks++;
    assert (bus.stall_cnt === got.sc) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", got.tag, bus.stall_cnt, got.sc);
    end
    checks++;
    assert (bus.flush_cnt === got.fc) else begin
      errors++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", got.tag, bus.flush_cnt, got.fc);
    end
    if (rst) begin
      exp_stall = 32'd0;
      exp_flush = 32'd0;
    end else begin
      exp_stall = exp_stall + {31'd0, ~ectl[5]};
      exp_flush = exp_flush + {31'd0, ectl[1]};
    end
  endtask

  initial begin
    errors              = 0;
    checks              = 0;
    exp_stall           = 32'd0;
    exp_flush           = 32'd0;
    reset               = 1'b1;
    bus.ex_is_load      = 1'b0;
    bus.ex_wb_addr      = 5'd0;
    bus.id_rs           = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    repeat (2) @(posedge clk);

    //    tag           rst  ld  wb    rs    urs  rt    urt  br   req  rdy  ctl      to
    step("reset",      1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RST,  1'b0);
    step("idle0",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("lu_rs",      1'b0,1'b1,5'd8,5'd8,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,C_LU,   1'b0);
    step("lu_rt",      1'b0,1'b1,5'd5,5'd0,1'b0,5'd5,1'b1,1'b0,1'b0,1'b0,C_LU,   1'b0);
    step("lu_unused",  1'b0,1'b1,5'd5,5'd5,1'b0,5'd5,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("lu_zero",    1'b0,1'b1,5'd0,5'd0,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("branch",     1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,C_BR,   1'b0);
    step("idle1",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("mw_enter",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("mw_wait1",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("mw_wait2",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("mw_ready",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b1,C_RUN,  1'b0);
    step("idle2",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("prio_all",   1'b0,1'b1,5'd8,5'd8,1'b1,5'd0,1'b0,1'b1,1'b1,1'b0,C_STALL,1'b0);
    step("prio_wait",  1'b0,1'b1,5'd8,5'd8,1'b1,5'd0,1'b0,1'b1,1'b1,1'b0,C_STALL,1'b0);
    step("prio_rdy_br",1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b1,1'b1,C_BR,   1'b0);
    step("idle3",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("prio_br_mw", 1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b1,1'b0,C_STALL,1'b0);
    step("prio_rdy_nb",1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b1,C_RUN,  1'b0);
    step("br_over_lu", 1'b0,1'b1,5'd8,5'd8,1'b1,5'd0,1'b0,1'b1,1'b0,1'b0,C_BR,   1'b0);
    step("to_enter",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("to_w0",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("to_w1",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("to_w2",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("to_w3",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b0);
    step("to_abort",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_RUN,  1'b0);
    step("to_sticky0", 1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b1);
    step("to_sticky1", 1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b1);
    step("rst_mw_in",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_STALL,1'b1);
    step("rst_in_mw",  1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,C_RST,  1'b1);
    step("post_rst",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);
    step("post_rst_lu",1'b0,1'b1,5'd3,5'd0,1'b0,5'd3,1'b1,1'b0,1'b0,1'b0,C_LU,   1'b0);
    step("final",      1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,C_RUN,  1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
